// File: rtl/i2s_tdm_clk_gen.sv
// I2S / TDM bit-clock and word-select generator.
// Divides clk_ref down to BCLK, tracks the slot/bit position and drives WS
// (stereo) or a one-BCLK frame sync (TDM). Supports I2S and left-justified
// framing. Start and stop are aligned to frame boundaries.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | parked at last slot/last bit, outputs static, waits for enable
//   RUN   | dividing clk_ref, toggling BCLK, advancing slot/bit position
module i2s_tdm_clk_gen #(
  parameter int BCLK_HALF_DIV = 24,
  parameter int SLOT_BITS     = 24,
  parameter int NUM_SLOTS     = 2
) (
  input  logic                         clk_ref,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  output logic                         clk_bit,
  output logic                         clk_ws,
  output logic                         frame_start,
  output logic                         tx_strobe,
  output logic                         rx_strobe,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
  output logic [$clog2(SLOT_BITS)-1:0] bit_idx
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int BW = $clog2(SLOT_BITS);
  // A divide of 1 still needs a 1-bit counter to keep the logic uniform
  localparam int DW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_SLOTS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_HALF_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic            mode_q;
  logic [DW-1:0]   div_cnt;
  logic [SW-1:0]   slot_nxt;
  logic [BW-1:0]   bit_nxt;
  logic            frame_wrap;

  // WS level for a position. I2S leads the data by one BCLK, so it looks one
  // bit ahead; left-justified uses the position as is.
  function automatic logic ws_for(input logic [SW-1:0] s,
                                  input logic [BW-1:0] b,
                                  input logic          lj);
    logic [SW-1:0] es;
    logic [BW-1:0] eb;
    es = s;
    eb = b;
    if (!lj) begin
      if (b == BIT_LAST) begin
        eb = '0;
        es = (s == SLOT_LAST) ? '0 : s + SW'(1);
      end else begin
        eb = b + BW'(1);
      end
    end
    if (NUM_SLOTS == 2) return (es == SW'(1));
    else                return (es == '0) && (eb == '0);
  endfunction

  // Position the next BCLK fall would move to
  always_comb begin
    bit_nxt  = bit_idx + BW'(1);
    slot_nxt = slot_idx;
    if (bit_idx == BIT_LAST) begin
      bit_nxt  = '0;
      slot_nxt = (slot_idx == SLOT_LAST) ? '0 : slot_idx + SW'(1);
    end
    frame_wrap = (slot_nxt == '0) && (bit_nxt == '0);
  end

  // Sequencer: divider, BCLK toggling, position tracking and frame-aligned stop
  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= 1'b0;
      div_cnt     <= '0;
      clk_bit     <= 1'b0;
      clk_ws      <= 1'b0;
      frame_start <= 1'b0;
      tx_strobe   <= 1'b0;
      rx_strobe   <= 1'b0;
      slot_idx    <= SLOT_LAST;
      bit_idx     <= BIT_LAST;
    end else begin
      frame_start <= 1'b0;
      tx_strobe   <= 1'b0;
      rx_strobe   <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= RUN;
            mode_q  <= mode;
            div_cnt <= '0;
            clk_ws  <= ws_for(slot_idx, bit_idx, mode);
          end
        end
        RUN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!clk_bit) begin
              clk_bit   <= 1'b1;
              rx_strobe <= 1'b1;
            end else if (frame_wrap && !enable) begin
              // End of frame with no run request: park without entering slot 0
              clk_bit <= 1'b0;
              state   <= IDLE;
            end else begin
              clk_bit     <= 1'b0;
              tx_strobe   <= 1'b1;
              slot_idx    <= slot_nxt;
              bit_idx     <= bit_nxt;
              frame_start <= frame_wrap;
              clk_ws      <= ws_for(slot_nxt, bit_nxt, mode_q);
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
